// File: rtl/bus_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, access sizes,
// the registered external request bundle and the alignment legality rule.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  typedef logic [1:0] mem_sz_t;

  localparam mem_sz_t SZ_B = 2'd0;
  localparam mem_sz_t SZ_H = 2'd1;
  localparam mem_sz_t SZ_W = 2'd2;

  // Address-independent part of the external request.
  // The address stays outside so that AW can remain a module parameter.
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ext_fields_t;

  // A half must sit on an even byte and a word on a 4-byte boundary.
  // The size code 3 is never legal.
  function automatic logic is_misaligned(input mem_sz_t sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational lane steering shared by every access: byte enables, write-data
// replication, read-data right-alignment with zero-extension, and a misalign flag.
module lane_align
  import bus_pkg::*;
(
  input  logic [1:0]  sz,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_aligned,
  output logic [31:0] rdata_aligned,
  output logic        misalign
);

  logic [31:0] rdata_shifted;

  assign rdata_shifted = rdata >> {addr_lo, 3'b000};
  assign misalign      = is_misaligned(sz, addr_lo);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
    be            = 4'h0;
    wdata_aligned = wdata;
    rdata_aligned = rdata_shifted;
    case (sz)
      SZ_B: begin
        be            = 4'b0001 << addr_lo;
        wdata_aligned = {4{wdata[7:0]}};
        rdata_aligned = {24'd0, rdata_shifted[7:0]};
      end
      SZ_H: begin
        be            = 4'b0011 << addr_lo;
        wdata_aligned = {2{wdata[15:0]}};
        rdata_aligned = {16'd0, rdata_shifted[15:0]};
      end
      SZ_W: begin
        be = 4'hF;
      end
      default: begin
        be = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (I) and data (D) requesters onto one external req/ack
// memory port. D normally wins, but I is forced through after STARVE_MAX consecutive D grants.
module mem_arbiter
  import bus_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_sz,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          d_err,
  output logic          ext_req,
  output logic          ext_we,
  output logic [AW-1:0] ext_addr,
  output logic [3:0]    ext_be,
  output logic [31:0]   ext_wdata,
  input  logic [31:0]   ext_rdata,
  input  logic          ext_ack
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  ext_fields_t   ext_q, ext_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    sz_q, sz_d;
  logic [1:0]    lo_q, lo_d;
  logic          i_ready_d, d_ready_d, d_err_d;
  logic [31:0]   i_rdata_d, d_rdata_d;

  logic          i_req_eff, d_req_eff, d_wins;
  logic [1:0]    la_sz, la_lo;
  logic [3:0]    la_be;
  logic [31:0]   la_wdata, la_rdata;
  logic          la_misalign;

  // A request seen alongside its own completion pulse is the one just served.
  assign i_req_eff = i_req & ~i_ready;
  assign d_req_eff = d_req & ~d_ready & ~d_err;
  assign d_wins    = d_req_eff & (~i_req_eff | (starve_q < STARVE_LIM));

  // In DBUSY the aligner serves the latched access (for read data); otherwise the live D request.
  assign la_sz = (state_q == DBUSY) ? sz_q : d_sz;
  assign la_lo = (state_q == DBUSY) ? lo_q : d_addr[1:0];

  lane_align u_lane_align (
    .sz            (la_sz),
    .addr_lo       (la_lo),
    .wdata         (d_wdata),
    .rdata         (ext_rdata),
    .be            (la_be),
    .wdata_aligned (la_wdata),
    .rdata_aligned (la_rdata),
    .misalign      (la_misalign)
  );

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    ext_d     = ext_q;
    addr_d    = addr_q;
    sz_d      = sz_q;
    lo_d      = lo_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    d_err_d   = 1'b0;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
    case (state_q)
      IDLE: begin
        if (d_wins) begin
          if (la_misalign) begin
            d_err_d = 1'b1;
          end else begin
            state_d = DBUSY;
            ext_d   = '{req: 1'b1, we: d_we, be: la_be, wdata: la_wdata};
            addr_d  = {d_addr[AW-1:2], 2'b00};
            sz_d    = d_sz;
            lo_d    = d_addr[1:0];
            if (i_req_eff && (starve_q < STARVE_LIM)) starve_d = starve_q + 1'b1;
          end
        end else if (i_req_eff) begin
          state_d   = IBUSY;
          ext_d.req = 1'b1;
          ext_d.we  = 1'b0;
          ext_d.be  = 4'hF;
          addr_d    = {i_addr[AW-1:2], 2'b00};
          starve_d  = '0;
        end
      end
      IBUSY: begin
        if (ext_ack) begin
          state_d   = IDLE;
          ext_d.req = 1'b0;
          ext_d.be  = 4'h0;
          i_ready_d = 1'b1;
          i_rdata_d = ext_rdata;
        end
      end
      DBUSY: begin
        if (ext_ack) begin
          state_d   = IDLE;
          ext_d.req = 1'b0;
          ext_d.be  = 4'h0;
          d_ready_d = 1'b1;
          d_rdata_d = ext_q.we ? 32'd0 : la_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      ext_q    <= '0;
      addr_q   <= '0;
      sz_q     <= '0;
      lo_q     <= '0;
      i_ready  <= 1'b0;
      d_ready  <= 1'b0;
      d_err    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      ext_q    <= ext_d;
      addr_q   <= addr_d;
      sz_q     <= sz_d;
      lo_q     <= lo_d;
      i_ready  <= i_ready_d;
      d_ready  <= d_ready_d;
      d_err    <= d_err_d;
      i_rdata  <= i_rdata_d;
      d_rdata  <= d_rdata_d;
    end
  end

  assign ext_req   = ext_q.req;
  assign ext_we    = ext_q.we;
  assign ext_be    = ext_q.be;
  assign ext_wdata = ext_q.wdata;
  assign ext_addr  = addr_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one external memory port between the core's instruction-fetch requester (I) and data requester (D).
- Sequences each access with a req/ack handshake on the external side.
- Generates byte enables and lane alignment for byte, half and word accesses.
- Returns data and a one-cycle ready pulse to the granting requester.
- Sits between the core's iaddr/idata and mem_* ports and the external SRAM/bus. The core wrapper splits inout mem_data into d_wdata/d_rdata and stalls the pipeline while a request is pending.

Parameters:
- STARVE_MAX, 4, consecutive D grants allowed while I is pending before I is forced to win.
- AW, 32, address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ready.
- i_addr  in  AW  fetch address; word-aligned.
- i_rdata  out  32  fetch data; valid when i_ready=1.
- i_ready  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held until d_ready or d_err.
- d_we  in  1  1 = write, 0 = read.
- d_sz  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- d_addr  in  AW  byte address.
- d_wdata  in  32  write data, right-aligned.
- d_rdata  out  32  read data, right-aligned, zero-extended.
- d_ready  out  1  one-cycle completion pulse.
- d_err  out  1  one-cycle misalign/illegal-size pulse.
- ext_req  out  1  external request, registered.
- ext_we  out  1  external write enable.
- ext_addr  out  AW  word address; low 2 bits are 0.
- ext_be  out  4  byte enables.
- ext_wdata  out  32  lane-replicated write data.
- ext_rdata  in  32  external read data; valid with ext_ack.
- ext_ack  in  1  completion; may assert in the first ext_req cycle.

Behaviour:
- Reset values: state IDLE; starve counter 0; ext_req, ext_we, i_ready, d_ready, d_err = 0; ext_be = 0; ext_addr, ext_wdata, i_rdata, d_rdata = 0.
- A port's req is ignored in any cycle where that port's ready or err output is high, so a held request is never regranted.
- States: IDLE, IBUSY, DBUSY.
- IDLE, D grant: D wins when d_req=1 and (i_req=0 or starve<STARVE_MAX).
  - Legal D: next state DBUSY. ext_req/we/addr/be/wdata are registered from D fields. starve increments if i_req=1, saturating.
  - Misaligned or illegal D (sz=1 with addr[0]=1; sz=2 with addr[1:0]≠0; sz=3): stay IDLE, pulse d_err next cycle, no external access, starve unchanged.
- IDLE, I grant: otherwise, if i_req=1, next state IBUSY with ext_we=0, be=4'hF, addr=i_addr&~3. starve clears to 0.
- IBUSY/DBUSY: ext_* held stable until ext_ack. On the edge sampling ext_ack=1:
  - ext_req and ext_be clear.
  - state returns to IDLE.
  - the granted port's ready pulses the next cycle, with rdata registered from ext_rdata.
- Minimum latency: req seen in IDLE at cycle 0 → ext_req at cycle 1 → ack at cycle 1 → ready at cycle 2. A new arbitration decision can happen in cycle 2.
- Byte enables: byte → 1<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'hF.
- Write data: byte → replicated to all 4 lanes; half → replicated to both halves; word → unchanged.
- Read data: ext_rdata >> (8·addr[1:0]), masked to 8/16/32 bits, zero-extended. Writes return d_rdata=0.
- Simultaneous i_req and d_req in IDLE resolve by the D-grant rule above. Exactly one ext transaction is outstanding at any time.
- rst mid-transaction: the next cycle shows reset values, and a later ext_ack is ignored. The external side must tolerate an abandoned request.
- ext_ack while IDLE is ignored.

Decomposition:
- bus_pkg holds:
  - arb_state_t enum {IDLE, IBUSY, DBUSY};
  - mem_sz_t constants SZ_B=0, SZ_H=1, SZ_W=2;
  - a struct grouping the ext_* request fields.
- One combinational sub-module, lane_align. Inputs: sz, addr[1:0], wdata, rdata. Outputs: be, aligned wdata, aligned rdata, misalign flag. It is instantiated once and shared, since only one access is outstanding.

Test Plan:
- I-only: i_req, i_addr=0x100, ack in same cycle with ext_rdata=0xDEADBEEF → ext_addr=0x100, be=F at cycle 1; i_ready=1 and i_rdata=0xDEADBEEF at cycle 2; no regrant at cycle 2.
- Byte store: d_we=1, sz=0, addr=0x203, wdata=0x000000AB → ext_addr=0x200, be=4'b1000, ext_wdata=0xABABABAB; d_ready after ack.
- Half load: sz=1, addr=0x302, ext_rdata=0x1234ABCD → d_rdata=0x00001234. Misaligned half at addr=0x301 → d_err pulse, ext_req stays 0.
- Contention: i_req and d_req both held continuously, ack after 1 wait cycle → grants D,D,D,D,I,D…; starve saturates at 4 then clears.
- Reset mid-op: rst asserted during DBUSY before ack; ack arrives the cycle after → ext_req=0 and d_ready=0 throughout, state IDLE.
